// File: rtl/decoder_scan_if.sv
// Handshake bundle between a select-code source and the decoder/scanner.
// Source drives enable, mode and select code; decoder returns the decode result.
// No backpressure: the source may change inputs every cycle.
interface decoder_scan_if #(
    parameter int N = 3
);
    logic            en;
    logic            mode;
    logic [N-1:0]    y;
    logic [2**N-1:0] d;
    logic [N-1:0]    idx;
    logic            wrap;

    modport master (output en, mode, y, input d, idx, wrap);
    modport slave  (input en, mode, y, output d, idx, wrap);
endinterface

// File: rtl/decoder_scan.sv
// One-hot decoder with direct-select and auto-scan (DWELL cycles per code) modes.
// Latency: one clock from sampled inputs to registered d/idx/wrap.
// No backpressure; en=0 blanks d and freezes scan state. Macro: DECODER_SCAN_ACTIVE_LOW_EN.
module decoder_scan #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst,
    decoder_scan_if.slave  bus
);
    localparam int             W     = 2**N;
    localparam logic [7:0]     DLAST = 8'(DWELL - 1);
    localparam logic [N-1:0]   ILAST = '1;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    // Active-low output: XOR the one-hot with all-ones, idle value is all-ones.
    localparam logic [W-1:0]   INV   = '1;
`else
    localparam logic [W-1:0]   INV   = '0;
`endif

    logic [N-1:0] scan_idx;   // code to be shown on the next enabled scan cycle
    logic [7:0]   dwell_cnt;  // cycles already spent on scan_idx
    logic         wrap_pend;  // next presented code 0 completes a sweep
    logic [W-1:0] d_q;
    logic [N-1:0] idx_q;
    logic         wrap_q;

    // Registered decode plus scan counters; direct mode keeps counters at zero
    // so entering scan always starts at code 0 with a full dwell and no wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx  <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
            d_q       <= INV;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
        end else if (!bus.mode) begin
            scan_idx  <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
            wrap_q    <= 1'b0;
            if (bus.en) begin
                d_q   <= (W'(1) << bus.y) ^ INV;
                idx_q <= bus.y;
            end else begin
                d_q   <= INV;
                idx_q <= '0;
            end
        end else if (bus.en) begin
            d_q    <= (W'(1) << scan_idx) ^ INV;
            idx_q  <= scan_idx;
            wrap_q <= wrap_pend;
            if (dwell_cnt == DLAST) begin
                dwell_cnt <= '0;
                scan_idx  <= scan_idx + 1'b1;
                wrap_pend <= (scan_idx == ILAST);
            end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
                wrap_pend <= 1'b0;
            end
        end else begin
            // Frozen scan: blank outputs, counters and pending wrap hold.
            d_q    <= INV;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end
    end

    assign bus.d    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances (DWELL=4 and DWELL=1) share the same stimulus.
// Expected outputs come from a position-count model: index = (pos/DWELL) mod 2**N.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_decoder_scan;
    localparam int N = 3;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder_scan_if #(.N(N)) b4 ();
    decoder_scan_if #(.N(N)) b1 ();

    decoder_scan #(.N(N), .DWELL(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    decoder_scan #(.N(N), .DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic [W-1:0] IDLE = 8'hFF;
`else
    localparam logic [W-1:0] IDLE = 8'h00;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int pos   = 0;   // enabled scan cycles since scan entry/reset

    logic [W-1:0] e4_d, e1_d;
    logic [N-1:0] e4_idx, e1_idx;
    logic         e4_w, e1_w;

    function automatic logic [W-1:0] onehot(input int k);
        logic [W-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return (IDLE == 8'hFF) ? ~v : v;
    endfunction

    // Apply one cycle of inputs to both instances and advance the model.
    task automatic cycle(input logic r, input logic e, input logic m, input logic [N-1:0] yy);
        @(negedge clk);
        rst = r;
        b4.en = e; b4.mode = m; b4.y = yy;
        b1.en = e; b1.mode = m; b1.y = yy;
        @(posedge clk);
        if (r) begin
            pos = 0;
            e4_d = IDLE; e4_idx = '0; e4_w = 1'b0;
            e1_d = IDLE; e1_idx = '0; e1_w = 1'b0;
        end else if (!m) begin
            pos = 0;
            e4_w = 1'b0; e1_w = 1'b0;
            if (e) begin
                e4_d = onehot(int'(yy)); e4_idx = yy;
                e1_d = onehot(int'(yy)); e1_idx = yy;
            end else begin
                e4_d = IDLE; e4_idx = '0;
                e1_d = IDLE; e1_idx = '0;
            end
        end else if (e) begin
            e4_idx = N'((pos / 4) % W);
            e4_d   = onehot((pos / 4) % W);
            e4_w   = (pos > 0) && (pos % (4 * W) == 0);
            e1_idx = N'(pos % W);
            e1_d   = onehot(pos % W);
            e1_w   = (pos > 0) && (pos % W == 0);
            pos++;
        end else begin
            e4_d = IDLE; e4_idx = '0; e4_w = 1'b0;
            e1_d = IDLE; e1_idx = '0; e1_w = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'($urandom), 1'($urandom), N'($urandom));
            n_cmp++;
            if ({b4.d, b4.idx, b4.wrap} !== {IDLE, 3'd0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_dw4 got d=%b idx=%0d wrap=%b want d=%b idx=0 wrap=0", b4.d, b4.idx, b4.wrap, IDLE);
            end
            n_cmp++;
            if ({b1.d, b1.idx, b1.wrap} !== {IDLE, 3'd0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_dw1 got d=%b idx=%0d wrap=%b want d=%b idx=0 wrap=0", b1.d, b1.idx, b1.wrap, IDLE);
            end
        end
    endtask

    task automatic test_direct();
        logic [W-1:0] want;
        for (int i = 0; i < W; i++) begin
            cycle(1'b0, 1'b1, 1'b0, N'(i));
            want = (IDLE == 8'hFF) ? ~(8'd1 << i) : (8'd1 << i);
            n_cmp++;
            if ({b4.d, b4.idx, b4.wrap} !== {want, N'(i), 1'b0}) begin
                n_err++;
                $display("FAIL direct_y%0d got d=%b idx=%0d wrap=%b want d=%b idx=%0d wrap=0", i, b4.d, b4.idx, b4.wrap, want, i);
            end
        end
    endtask

    task automatic test_enable();
        cycle(1'b0, 1'b0, 1'b0, 3'b010);
        n_cmp++;
        if ({b4.d, b4.idx, b4.wrap} !== {IDLE, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL enable_low got d=%b idx=%0d wrap=%b want d=%b idx=0 wrap=0", b4.d, b4.idx, b4.wrap, IDLE);
        end
        cycle(1'b0, 1'b1, 1'b0, 3'b010);
        n_cmp++;
        if ({b4.d, b4.idx, b4.wrap} !== {IDLE ^ 8'b0000_0100, 3'd2, 1'b0}) begin
            n_err++;
            $display("FAIL enable_high got d=%b idx=%0d wrap=%b want d=%b idx=2 wrap=0", b4.d, b4.idx, b4.wrap, IDLE ^ 8'b0000_0100);
        end
    endtask

    // Shared per-cycle comparison of both instances against the model.
    `define CMP_BOTH(tag, cyc) \
        n_cmp++; \
        if ({b4.d, b4.idx, b4.wrap} !== {e4_d, e4_idx, e4_w}) begin \
            n_err++; \
            $display("FAIL %s_dw4 cyc=%0d got d=%b idx=%0d wrap=%b want d=%b idx=%0d wrap=%b", tag, cyc, b4.d, b4.idx, b4.wrap, e4_d, e4_idx, e4_w); \
        end \
        n_cmp++; \
        if ({b1.d, b1.idx, b1.wrap} !== {e1_d, e1_idx, e1_w}) begin \
            n_err++; \
            $display("FAIL %s_dw1 cyc=%0d got d=%b idx=%0d wrap=%b want d=%b idx=%0d wrap=%b", tag, cyc, b1.d, b1.idx, b1.wrap, e1_d, e1_idx, e1_w); \
        end

    task automatic test_scan();
        int wraps;
        wraps = 0;
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b1, 1'b1, N'($urandom));
            `CMP_BOTH("scan", i)
            if (b4.wrap === 1'b1) wraps++;
            if (i == 33) begin
                n_cmp++;
                if ({b4.wrap, b4.idx} !== {1'b1, 3'd0}) begin
                    n_err++;
                    $display("FAIL scan_wrap33 got wrap=%b idx=%0d want wrap=1 idx=0", b4.wrap, b4.idx);
                end
            end
        end
        n_cmp++;
        if (wraps != 1) begin
            n_err++;
            $display("FAIL scan_wrap_count got %0d want 1", wraps);
        end
    endtask

    task automatic test_freeze();
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 22; i++) cycle(1'b0, 1'b1, 1'b1, N'($urandom));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, N'($urandom));
            `CMP_BOTH("freeze", i)
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, N'($urandom));
            `CMP_BOTH("resume", i)
            n_cmp++;
            if (b4.idx !== ((i < 2) ? 3'd5 : 3'd6)) begin
                n_err++;
                $display("FAIL resume_idx cyc=%0d got idx=%0d want %0d", i, b4.idx, (i < 2) ? 5 : 6);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 26; i++) cycle(1'b0, 1'b1, 1'b1, N'($urandom));
        cycle(1'b1, 1'b1, 1'b1, N'($urandom));
        `CMP_BOTH("rst_mid", 0)
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, N'($urandom));
            `CMP_BOTH("after_rst", i)
        end
    endtask

    task automatic test_random();
        logic m;
        m = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) m = ~m;
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0), m, N'($urandom));
            `CMP_BOTH("random", i)
        end
    endtask

    initial begin
        b4.en = 1'b0; b4.mode = 1'b0; b4.y = '0;
        b1.en = 1'b0; b1.mode = 1'b0; b1.y = '0;
        test_reset();
        test_direct();
        test_enable();
        test_scan();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning select width; output width is 2**N; legal range 1..6.
REQ-002 The block SHALL have parameter DWELL, default 4, meaning clock cycles each output is held in scan mode; legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port en  input  1  enable; when low, d is all-inactive and scan state is frozen.
REQ-006 The block SHALL have port mode  input  1  mode select: 0 = direct decode of y, 1 = auto-scan.
REQ-007 The block SHALL have port y  input  N  select code, used in direct mode only.
REQ-008 The block SHALL have port d  output  2**N  registered one-hot decode output.
REQ-009 The block SHALL have port idx  output  N  registered index of the active d bit; 0 when d is inactive.
REQ-010 The block SHALL have port wrap  output  1  single-cycle pulse marking completion of a full scan sweep.

Function
REQ-011 All outputs SHALL be registered, with one clock of latency from a sampled input to the output.
REQ-012 In direct mode with en=1, the block SHALL make d = 1<<y and idx = y one cycle after y is sampled; wrap SHALL be 0.
REQ-013 With en=0 in either mode, the block SHALL make d all-inactive, idx=0 and wrap=0 on the next cycle.
REQ-014 In scan mode, the block SHALL hold an internal index counter (N bits) and an internal dwell counter (0..DWELL-1).
REQ-015 In scan mode with en=1, the dwell counter SHALL increment each cycle; when it equals DWELL-1 it SHALL return to 0 and the index SHALL increment by 1.
REQ-016 The index SHALL wrap from 2**N-1 to 0.
REQ-017 On the wrap transition, wrap SHALL be 1 for exactly the one cycle in which idx first shows 0.
REQ-018 In scan mode, d SHALL equal 1<<index and idx SHALL equal index, so each code is held for exactly DWELL cycles.
REQ-019 When DWELL=1, the index SHALL advance every enabled cycle.
REQ-020 When en is low in scan mode, the index and dwell counters SHALL hold their values, and scanning SHALL resume from the held state when en returns high.
REQ-021 When mode changes from 0 to 1, the block SHALL clear the index and dwell counters in that cycle, so the first scan output is code 0 held for the full DWELL cycles; no wrap pulse SHALL occur.
REQ-022 When mode changes from 1 to 0, the next output SHALL be the direct decode of y; scan state SHALL be discarded.
REQ-023 When en=0 and a mode change occur together, REQ-013 SHALL take precedence for the outputs, and REQ-021 or REQ-022 SHALL apply to the counters.
REQ-024 y SHALL be ignored in scan mode.

Reset
REQ-025 While rst=1 on a clock edge, the block SHALL make d all-inactive, idx=0, wrap=0, index counter=0 and dwell counter=0.
REQ-026 rst SHALL override en, mode and y, including mid-dwell and mid-sweep.
REQ-027 After rst falls, the first scan output SHALL be code 0 held for the full DWELL cycles.

Configuration
REQ-028 With macro DECODER_SCAN_ACTIVE_LOW_EN defined, d SHALL be active-low: the selected bit is 0 and the other bits are 1, and the all-inactive value is all-ones, including during reset.
REQ-029 Without DECODER_SCAN_ACTIVE_LOW_EN, d SHALL be active-high and its all-inactive value SHALL be all-zeros.
REQ-030 idx and wrap SHALL be unaffected by DECODER_SCAN_ACTIVE_LOW_EN.

Verification
REQ-031 Direct mode, N=3: rst, then en=1, mode=0, y=000..111 one per cycle -> each cycle after input, d=00000001, 00000010 ... 10000000, and idx equals y.
REQ-032 Enable gating: en=0 with y=010 -> d=00000000 and idx=0 the next cycle; raising en -> d=00000100 one cycle later.
REQ-033 Scan, N=3, DWELL=4: 40 cycles with en=1, mode=1 -> d steps 00000001 to 10000000 with each value held 4 cycles; wrap=1 in the single cycle d returns to 00000001 (cycle 33 after entry).
REQ-034 Freeze and resume: drop en for 5 cycles at index 5 after 2 cycles of dwell -> d=0 during the freeze; on resume, index 5 is held for the remaining 2 cycles, then index 6.
REQ-035 Reset mid-sweep: assert rst at index 6 -> next cycle d=0, idx=0; after release, code 0 is held for 4 cycles; also rerun with DWELL=1 -> index advances every cycle.
REQ-036 Macro build: with DECODER_SCAN_ACTIVE_LOW_EN defined, direct y=011 -> d=11110111; during reset -> d=11111111.
